// File: rtl/cache_pkg.sv
// Shared cache-subsystem constants, address field positions and the
// memory-port arbiter state type.
package cache_pkg;

    localparam int unsigned WORD_WIDTH        = 32;
    localparam int unsigned ADR_WIDTH         = 32;
    localparam int unsigned WORD_OFFSET_WIDTH = 2;
    localparam int unsigned BYTE_OFFSET_WIDTH = 2;
    localparam int unsigned WORD_NUM          = 2 ** WORD_OFFSET_WIDTH;

    // Address field positions within a byte address
    localparam int unsigned WOFS_LSB  = 2;
    localparam int unsigned WOFS_MSB  = 3;
    localparam int unsigned INDEX_LSB = 4;
    localparam int unsigned INDEX_MSB = 10;
    localparam int unsigned TAG_LSB   = 11;
    localparam int unsigned TAG_MSB   = 31;

    // Memory-port arbiter states
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// master that did not own the previous burst.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner from the current requests and the previous owner
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last_owner;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between the icache (M0) and dcache (M1).
// Each grant is a locked WORD_NUM-beat burst that starts at the critical
// word and wraps within the line; ties are resolved round robin.
module mem_port_arbiter
    import cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         m0_req_i,
    input  logic                         m0_we_i,
    input  logic [ADR_WIDTH-1:0]         m0_adr_i,
    input  logic [WORD_WIDTH-1:0]        m0_dat_i,
    output logic                         m0_gnt_o,
    output logic                         m0_ack_o,
    output logic [WORD_WIDTH-1:0]        m0_dat_o,
    output logic [WORD_OFFSET_WIDTH-1:0] m0_word_o,
    output logic                         m0_last_o,

    input  logic                         m1_req_i,
    input  logic                         m1_we_i,
    input  logic [ADR_WIDTH-1:0]         m1_adr_i,
    input  logic [WORD_WIDTH-1:0]        m1_dat_i,
    output logic                         m1_gnt_o,
    output logic                         m1_ack_o,
    output logic [WORD_WIDTH-1:0]        m1_dat_o,
    output logic [WORD_OFFSET_WIDTH-1:0] m1_word_o,
    output logic                         m1_last_o,

    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADR_WIDTH-1:0]         mem_adr_o,
    output logic [WORD_WIDTH-1:0]        mem_dat_o,
    input  logic                         mem_ack_i,
    input  logic [WORD_WIDTH-1:0]        mem_dat_i
);

    localparam int unsigned LINE_LSB = WORD_OFFSET_WIDTH + BYTE_OFFSET_WIDTH;

    arb_state_t                   r_state;
    arb_state_t                   w_state_nxt;
    logic                         r_owner;
    logic                         r_last_owner;
    logic [WORD_OFFSET_WIDTH-1:0] r_start_word;
    logic [WORD_OFFSET_WIDTH-1:0] r_beat_cnt;

    logic                         w_gnt_valid;
    logic                         w_gnt_id;
    logic                         w_burst;
    logic                         w_beat_last;
    logic [WORD_OFFSET_WIDTH-1:0] w_beat_word;
    logic [WORD_OFFSET_WIDTH-1:0] w_req_word;
    logic [ADR_WIDTH-1:0]         w_own_adr;
    logic [WORD_WIDTH-1:0]        w_own_dat;
    logic                         w_own_we;
    logic                         w_unused;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req_i, m0_req_i}),
        .last_owner (r_last_owner),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    assign w_burst     = (r_state == ARB_BURST);
    assign w_beat_last = (r_beat_cnt == WORD_OFFSET_WIDTH'(WORD_NUM - 1));
    // Natural overflow of the word-offset width gives the in-line wrap
    assign w_beat_word = r_start_word + r_beat_cnt;
    assign w_req_word  = w_gnt_id ? m1_adr_i[LINE_LSB-1:BYTE_OFFSET_WIDTH]
                                  : m0_adr_i[LINE_LSB-1:BYTE_OFFSET_WIDTH];
    assign w_own_adr   = r_owner ? m1_adr_i : m0_adr_i;
    assign w_own_dat   = r_owner ? m1_dat_i : m0_dat_i;
    assign w_own_we    = r_owner ? m1_we_i  : m0_we_i;
    // Byte-in-word bits of the request addresses are never forwarded
    assign w_unused    = ^{m0_adr_i[BYTE_OFFSET_WIDTH-1:0], m1_adr_i[BYTE_OFFSET_WIDTH-1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start a burst on any request, end it on the last acked beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_gnt_valid)              w_state_nxt = ARB_BURST;
            ARB_BURST: if (mem_ack_i && w_beat_last) w_state_nxt = ARB_IDLE;
            default:                                 w_state_nxt = ARB_IDLE;
        endcase
    end

    // Burst bookkeeping: owner, critical word, beat count, round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_start_word <= '0;
            r_beat_cnt   <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_gnt_valid) begin
                r_owner      <= w_gnt_id;
                r_start_word <= w_req_word;
                r_beat_cnt   <= '0;
            end
        end else if (mem_ack_i) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_beat_last) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Outputs: memory side follows the owner, master side sees only its own beats
    always_comb begin
        m0_gnt_o  = 1'b0;
        m0_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m0_word_o = '0;
        m0_last_o = 1'b0;
        m1_gnt_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_dat_o  = '0;
        m1_word_o = '0;
        m1_last_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_adr_o = '0;
        mem_dat_o = '0;
        if (w_burst) begin
            mem_req_o = 1'b1;
            mem_we_o  = w_own_we;
            mem_adr_o = {w_own_adr[ADR_WIDTH-1:LINE_LSB], w_beat_word, {BYTE_OFFSET_WIDTH{1'b0}}};
            mem_dat_o = w_own_dat;
            if (r_owner) begin
                m1_gnt_o  = 1'b1;
                m1_word_o = w_beat_word;
                m1_ack_o  = mem_ack_i;
                m1_last_o = mem_ack_i & w_beat_last;
                m1_dat_o  = mem_ack_i ? mem_dat_i : '0;
            end else begin
                m0_gnt_o  = 1'b1;
                m0_word_o = w_beat_word;
                m0_ack_o  = mem_ack_i;
                m0_last_o = mem_ack_i & w_beat_last;
                m0_dat_o  = mem_ack_i ? mem_dat_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a burst-level reference model
// queues the expected beats of each granted burst, a monitor compares them
// against the memory and master ports every cycle.
module tb_mem_port_arbiter;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic        m0_gnt_o, m0_ack_o, m0_last_o, m1_gnt_o, m1_ack_o, m1_last_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic [1:0]  m0_word_o, m1_word_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;

    // Stimulus state per master
    logic [1:0]  t_req = '0;
    logic [1:0]  t_we  = '0;
    logic [31:0] t_adr [2];
    bit          active [2];
    bit          seen_ack [2];
    bit          seen_last [2];
    int unsigned ack_cnt [2];
    int unsigned last_cnt [2];
    bit          auto_issue = 0;
    bit          drop_en = 0;
    int unsigned ack_mode = 1;
    bit          tog = 1'b0;
    int unsigned req_cycles = 0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Observed acked beats, for order checks in directed tests
    int unsigned log_m [$];
    logic [31:0] log_adr [$];
    logic [1:0]  log_word [$];

    typedef struct {
        int unsigned m;
        logic        we;
        logic [31:0] adr;
        logic [1:0]  word;
        logic        last;
        logic [31:0] wd;
    } beat_t;
    beat_t exp_q [$];

    bit          md_busy = 0;
    int unsigned md_rem = 0;
    int unsigned md_last_owner = 1;

    assign m0_req_i = t_req[0];
    assign m1_req_i = t_req[1];
    assign m0_we_i  = t_we[0];
    assign m1_we_i  = t_we[1];
    assign m0_adr_i = t_adr[0];
    assign m1_adr_i = t_adr[1];
    // Write data is a known function of master, line address and word index
    assign m0_dat_i = wdata(0, m0_adr_i, m0_word_o);
    assign m1_dat_i = wdata(1, m1_adr_i, m1_word_o);

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req_i  (m0_req_i),
        .m0_we_i   (m0_we_i),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_gnt_o  (m0_gnt_o),
        .m0_ack_o  (m0_ack_o),
        .m0_dat_o  (m0_dat_o),
        .m0_word_o (m0_word_o),
        .m0_last_o (m0_last_o),
        .m1_req_i  (m1_req_i),
        .m1_we_i   (m1_we_i),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_gnt_o  (m1_gnt_o),
        .m1_ack_o  (m1_ack_o),
        .m1_dat_o  (m1_dat_o),
        .m1_word_o (m1_word_o),
        .m1_last_o (m1_last_o),
        .mem_req_o (mem_req_o),
        .mem_we_o  (mem_we_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_ack_i (mem_ack_i),
        .mem_dat_i (mem_dat_i)
    );

    function automatic logic [31:0] wdata(int unsigned m, logic [31:0] adr, logic [1:0] w);
        return ((m == 0) ? 32'hD000_0000 : 32'hE100_0000) ^ adr ^ {30'b0, w};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one burst of WORD_NUM wrapping beats per grant
    initial begin
        int unsigned w;
        int unsigned sw;
        beat_t e;
        t_adr[0] = '0;
        t_adr[1] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                md_busy = 0;
                md_rem = 0;
                md_last_owner = 1;
            end else if (md_busy) begin
                if (mem_ack_i) begin
                    md_rem--;
                    if (md_rem == 0) md_busy = 0;
                end
            end else if (t_req != 2'b00) begin
                if (t_req == 2'b11) w = 1 - md_last_owner;
                else                w = t_req[1] ? 1 : 0;
                sw = t_adr[w][3:2];
                for (int unsigned b = 0; b < WORD_NUM; b++) begin
                    e.m    = w;
                    e.we   = t_we[w];
                    e.word = 2'((sw + b) % WORD_NUM);
                    e.adr  = {t_adr[w][31:4], 4'b0000} + 32'((sw + b) % WORD_NUM) * 4;
                    e.last = (b == WORD_NUM - 1);
                    e.wd   = wdata(w, t_adr[w], e.word);
                    exp_q.push_back(e);
                end
                md_busy = 1;
                md_rem = WORD_NUM;
                md_last_owner = w;
            end
        end
    end

    // Monitor: compare DUT outputs with the head of the expected-beat queue
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (md_busy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = exp_q[0];
                    req_cycles++;
                    chk("mem_req", mem_req_o, 1);
                    chk("gnt0", m0_gnt_o, e.m == 0);
                    chk("gnt1", m1_gnt_o, e.m == 1);
                    chk("mem_adr", mem_adr_o, e.adr);
                    chk("mem_we", mem_we_o, e.we);
                    chk("mem_dat", mem_dat_o, e.wd);
                    chk("word", (e.m == 0) ? m0_word_o : m1_word_o, e.word);
                    if (mem_ack_i) begin
                        chk("own_ack", (e.m == 0) ? m0_ack_o : m1_ack_o, 1);
                        chk("other_ack", (e.m == 0) ? m1_ack_o : m0_ack_o, 0);
                        chk("own_last", (e.m == 0) ? m0_last_o : m1_last_o, e.last);
                        chk("other_last", (e.m == 0) ? m1_last_o : m0_last_o, 0);
                        chk("rd_dat", (e.m == 0) ? m0_dat_o : m1_dat_o, mem_dat_i);
                        log_m.push_back(m1_ack_o ? 1 : 0);
                        log_adr.push_back(mem_adr_o);
                        log_word.push_back((e.m == 0) ? m0_word_o : m1_word_o);
                        seen_ack[e.m] = 1;
                        ack_cnt[e.m]++;
                        if (e.last) begin
                            seen_last[e.m] = 1;
                            last_cnt[e.m]++;
                        end
                        void'(exp_q.pop_front());
                    end else begin
                        chk("wait_ack", {m1_ack_o, m0_ack_o}, 0);
                        chk("wait_last", {m1_last_o, m0_last_o}, 0);
                    end
                end
            end else begin
                chk("idle_req", mem_req_o, 0);
                chk("idle_we", mem_we_o, 0);
                chk("idle_gnt", {m1_gnt_o, m0_gnt_o}, 0);
                chk("idle_ack", {m1_ack_o, m0_ack_o}, 0);
                chk("idle_last", {m1_last_o, m0_last_o}, 0);
                chk("idle_adr", mem_adr_o, 0);
                chk("idle_mdat", mem_dat_o, 0);
                chk("idle_word", {m1_word_o, m0_word_o}, 0);
                chk("idle_dat0", m0_dat_o, 0);
                chk("idle_dat1", m1_dat_o, 0);
            end
        end
    end

    // One cycle of stimulus, driven just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                active[m] = 0;
                t_req[m] = 1'b0;
            end else if (active[m]) begin
                if (seen_last[m]) begin
                    active[m] = 0;
                    t_req[m] = 1'b0;
                end else if (drop_en && t_req[m] && seen_ack[m] && $urandom_range(7) == 0) begin
                    t_req[m] = 1'b0;
                end
            end else if (auto_issue && $urandom_range(2) == 0) begin
                active[m] = 1;
                t_req[m] = 1'b1;
                t_adr[m] = $urandom;
                t_we[m] = 1'($urandom_range(1));
            end
            seen_last[m] = 0;
            seen_ack[m] = 0;
        end
        case (ack_mode)
            0: mem_ack_i = ($urandom_range(3) != 0);
            2: begin mem_ack_i = tog; tog = ~tog; end
            default: mem_ack_i = 1'b1;
        endcase
        mem_dat_i = $urandom;
    endtask

    task automatic start_req(int m, logic [31:0] adr, logic we);
        active[m] = 1;
        t_req[m] = 1'b1;
        t_adr[m] = adr;
        t_we[m] = we;
    endtask

    task automatic wait_last(int m, int budget);
        int unsigned base;
        bit done;
        base = last_cnt[m];
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (last_cnt[m] > base) done = 1;
        end
        if (!done) chk("last_timeout", 0, 1);
    endtask

    task automatic clear_log();
        log_m.delete();
        log_adr.delete();
        log_word.delete();
    endtask

    initial begin
        logic [31:0] exp_a [4];
        logic [1:0]  exp_w [4];
        int unsigned base;
        exp_a = '{32'h0000_1238, 32'h0000_123C, 32'h0000_1230, 32'h0000_1234};
        exp_w = '{2'd2, 2'd3, 2'd0, 2'd1};
        mem_ack_i = 1'b0;
        mem_dat_i = '0;

        // Reset: monitor checks all outputs are zero while idle
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single read from the critical word, zero-wait memory
        clear_log();
        ack_mode = 1;
        start_req(0, 32'h0000_1238, 1'b0);
        wait_last(0, 20);
        chk("t1_beats", log_m.size(), 4);
        for (int i = 0; i < 4 && i < log_adr.size(); i++) begin
            chk("t1_adr", log_adr[i], exp_a[i]);
            chk("t1_word", log_word[i], exp_w[i]);
            chk("t1_master", log_m[i], 0);
        end
        step();

        // Tie after reset, then M0 re-requests during the M1 burst
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        clear_log();
        start_req(0, 32'h0000_2000, 1'b0);
        start_req(1, 32'h0000_3004, 1'b1);
        wait_last(0, 20);
        start_req(0, 32'h0000_2010, 1'b0);
        wait_last(1, 20);
        wait_last(0, 20);
        chk("t2_beats", log_m.size(), 12);
        if (log_m.size() >= 12) begin
            chk("t2_first", log_m[0], 0);
            chk("t2_second", log_m[4], 1);
            chk("t2_third", log_m[8], 0);
        end
        step();

        // Write burst with alternating acks: acks land on burst cycles 1,3,5,7
        ack_mode = 2;
        tog = 1'b1;
        req_cycles = 0;
        start_req(1, 32'h0000_0400, 1'b1);
        wait_last(1, 30);
        chk("t3_req_cycles", req_cycles, 7);
        step();

        // M1 requests mid-burst while M0 drops its request after beat 1
        ack_mode = 1;
        clear_log();
        base = ack_cnt[0];
        start_req(0, 32'h0000_5558, 1'b0);
        for (int i = 0; i < 20 && ack_cnt[0] < base + 1; i++) step();
        start_req(1, 32'h0000_6000, 1'b0);
        t_req[0] = 1'b0;
        wait_last(0, 20);
        wait_last(1, 20);
        chk("t4_beats", log_m.size(), 8);
        if (log_m.size() >= 8) begin
            chk("t4_m0_last", log_m[3], 0);
            chk("t4_m1_first", log_m[4], 1);
        end
        step();

        // Reset at beat 2, then a tie must go to M0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        base = ack_cnt[0];
        start_req(0, 32'h0000_7000, 1'b0);
        for (int i = 0; i < 20 && ack_cnt[0] < base + 2; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_log();
        start_req(0, 32'h0000_7100, 1'b0);
        start_req(1, 32'h0000_7200, 1'b0);
        wait_last(0, 20);
        chk("t6_beats", log_m.size(), 4);
        if (log_m.size() >= 1) chk("t6_first", log_m[0], 0);
        wait_last(1, 20);

        // Random traffic, random wait states, occasional early request drop
        ack_mode = 0;
        auto_issue = 1;
        drop_en = 1;
        repeat (4000) step();
        auto_issue = 0;
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
